// File: rtl/booth_ctrl.sv
// booth_ctrl: Moore sequencer issuing the c0..c6 strobes of a radix-2 Booth multiplier.
// Latency 2N+4..3N+4 cycles start-to-done; start is ignored while busy, nothing is queued.
module booth_ctrl #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst_b,
    input  logic start,
    input  logic q0,
    input  logic q_m1,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic c3,
    output logic c4,
    output logic c5,
    output logic c6,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_TEST,
        ST_ADD,
        ST_SUB,
        ST_SHIFT,
        ST_OUT_A,
        ST_OUT_Q,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Booth pair {q0,q_m1} only matters in TEST; everywhere else it is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                state_d = ST_TEST;
                cnt_d   = '0;
            end
            ST_TEST: begin
                case ({q0, q_m1})
                    2'b01:   state_d = ST_ADD;
                    2'b10:   state_d = ST_SUB;
                    default: state_d = ST_SHIFT;
                endcase
            end
            ST_ADD:   state_d = ST_SHIFT;
            ST_SUB:   state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_OUT_A;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_TEST;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_OUT_A: state_d = ST_OUT_Q;
            ST_OUT_Q: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Strobes decode from the state register alone so reset clears them without a clock.
    always_comb begin
        c0   = 1'b0;
        c1   = 1'b0;
        c2   = 1'b0;
        c3   = 1'b0;
        c4   = 1'b0;
        c5   = 1'b0;
        c6   = 1'b0;
        busy = (state_q != ST_IDLE);
        done = 1'b0;
        case (state_q)
            ST_INIT: begin
                c0 = 1'b1;
                c1 = 1'b1;
            end
            ST_ADD:   c2 = 1'b1;
            ST_SUB: begin
                c2 = 1'b1;
                c3 = 1'b1;
            end
            ST_SHIFT: c4 = 1'b1;
            ST_OUT_A: c5 = 1'b1;
            ST_OUT_Q: c6 = 1'b1;
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    a_datapath_excl: assert property (@(posedge clk) disable iff (!rst_b)
        $onehot0({c0, c2, c4}));
    a_bus_excl: assert property (@(posedge clk) disable iff (!rst_b)
        !(c5 && c6));

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: random Booth pairs against a cycle-schedule model built from the state/strobe table.
module tb_booth_ctrl;

    localparam int N = 8;

    // Observed word layout: {c0,c1,c2,c3,c4,c5,c6,busy,done}
    localparam logic [8:0] W_IDLE  = 9'b000000000;
    localparam logic [8:0] W_INIT  = 9'b110000010;
    localparam logic [8:0] W_TEST  = 9'b000000010;
    localparam logic [8:0] W_ADD   = 9'b001000010;
    localparam logic [8:0] W_SUB   = 9'b001100010;
    localparam logic [8:0] W_SHIFT = 9'b000010010;
    localparam logic [8:0] W_OUTA  = 9'b000001010;
    localparam logic [8:0] W_OUTQ  = 9'b000000110;
    localparam logic [8:0] W_DONE  = 9'b000000011;

    logic clk, rst_b, start, q0, q_m1;
    logic c0, c1, c2, c3, c4, c5, c6, busy, done;
    logic [8:0] obs;

    int errors = 0;
    int checks = 0;

    logic [1:0] pat [N];
    logic [8:0] exp_q [$];
    logic [1:0] drv_q [$];
    logic [8:0] obs_q [$];
    logic [8:0] abort_obs;

    booth_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .start (start),
        .q0    (q0),
        .q_m1  (q_m1),
        .c0    (c0),
        .c1    (c1),
        .c2    (c2),
        .c3    (c3),
        .c4    (c4),
        .c5    (c5),
        .c6    (c6),
        .busy  (busy),
        .done  (done)
    );

    assign obs = {c0, c1, c2, c3, c4, c5, c6, busy, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-cycle outputs, and the Booth pair to present in each cycle.
    function automatic void model_build();
        exp_q.delete();
        drv_q.delete();
        exp_q.push_back(W_INIT);
        drv_q.push_back(2'($urandom));
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(W_TEST);
            drv_q.push_back(pat[i]);
            if (pat[i] == 2'b01) begin
                exp_q.push_back(W_ADD);
                drv_q.push_back(2'($urandom));
            end else if (pat[i] == 2'b10) begin
                exp_q.push_back(W_SUB);
                drv_q.push_back(2'($urandom));
            end
            exp_q.push_back(W_SHIFT);
            drv_q.push_back(2'($urandom));
        end
        exp_q.push_back(W_OUTA);
        drv_q.push_back(2'($urandom));
        exp_q.push_back(W_OUTQ);
        drv_q.push_back(2'($urandom));
        exp_q.push_back(W_DONE);
        drv_q.push_back(2'($urandom));
    endfunction

    function automatic int model_latency();
        int lat = 4;
        for (int i = 0; i < N; i++) lat += (pat[i] == 2'b01 || pat[i] == 2'b10) ? 3 : 2;
        return lat;
    endfunction

    function automatic int model_adds();
        int n = 0;
        for (int i = 0; i < N; i++) if (pat[i] == 2'b01 || pat[i] == 2'b10) n++;
        return n;
    endfunction

    function automatic int obs_done_cyc();
        for (int k = 0; k < obs_q.size(); k++) if (obs_q[k][0]) return k + 1;
        return -1;
    endfunction

    function automatic int obs_count(input int bitpos);
        int n = 0;
        for (int k = 0; k < obs_q.size(); k++) if (obs_q[k][bitpos]) n++;
        return n;
    endfunction

    // Entered and left #1 after a rising edge; records one sample per cycle at the falling edge.
    task automatic drive_op(input bit launched, input bit hold, input int ign_cyc,
                            input int abort_cyc);
        obs_q.delete();
        if (!launched) begin
            start = 1'b1;
            {q0, q_m1} = 2'($urandom);
            @(posedge clk); #1;
        end
        for (int k = 0; k < drv_q.size(); k++) begin
            start = (k + 1 == ign_cyc) ? 1'b1 : hold;
            {q0, q_m1} = drv_q[k];
            @(negedge clk);
            obs_q.push_back(obs);
            if (k + 1 == abort_cyc) begin
                #2 rst_b = 1'b0;
                #1 abort_obs = obs;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        start = 1'b1;
        {q0, q_m1} = 2'b01;
        rst_b = 1'b0;
        #1;
        checks++;
        if (obs !== W_IDLE) begin
            errors++;
            $display("FAIL reset_async: got %b want %b", obs, W_IDLE);
        end
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        rst_b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== W_IDLE) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: got %b want %b", k, obs, W_IDLE);
            end
            @(posedge clk); #1;
        end
    endtask

    // 00 held, 01 held, 10 held, then 01/10 alternating per iteration.
    task automatic test_patterns();
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < N; i++)
                pat[i] = (m == 0) ? 2'b00 : (m == 1) ? 2'b01 : (m == 2) ? 2'b10 :
                         ((i % 2 == 0) ? 2'b01 : 2'b10);
            model_build();
            drive_op(1'b0, 1'b0, 0, 0);
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL pattern%0d cyc%0d: got %b want %b", m, k + 1, obs_q[k], exp_q[k]);
                end
            end
            checks++;
            if (obs_done_cyc() !== ((m == 0) ? 20 : 28)) begin
                errors++;
                $display("FAIL pattern%0d done_cycle: got %0d want %0d", m, obs_done_cyc(),
                         (m == 0) ? 20 : 28);
            end
            checks++;
            if (obs_count(6) !== ((m == 0) ? 0 : N) || obs_count(4) !== N) begin
                errors++;
                $display("FAIL pattern%0d pulses: c2=%0d c4=%0d want c2=%0d c4=%0d", m,
                         obs_count(6), obs_count(4), (m == 0) ? 0 : N, N);
            end
            checks++;
            if (obs_count(5) !== ((m == 2) ? N : (m == 3) ? N / 2 : 0)) begin
                errors++;
                $display("FAIL pattern%0d sub_count: got %0d", m, obs_count(5));
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) pat[i] = 2'($urandom_range(0, 3));
            model_build();
            drive_op(1'b0, 1'b0, 0, 0);
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL random%0d cyc%0d: got %b want %b", r, k + 1, obs_q[k], exp_q[k]);
                end
            end
            checks++;
            if (obs_done_cyc() !== model_latency() || obs_count(6) !== model_adds()) begin
                errors++;
                $display("FAIL random%0d latency: done=%0d c2=%0d want done=%0d c2=%0d", r,
                         obs_done_cyc(), obs_count(6), model_latency(), model_adds());
            end
            // gap cycle between operations
            @(negedge clk);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N; i++) pat[i] = 2'b00;
        model_build();
        drive_op(1'b0, 1'b0, 6, 0);
        checks++;
        if (obs_done_cyc() !== 20 || obs_count(0) !== 1) begin
            errors++;
            $display("FAIL busy_ignore: done_cycle=%0d done_pulses=%0d want 20 and 1",
                     obs_done_cyc(), obs_count(0));
        end
        for (int i = 0; i < N; i++) pat[i] = 2'($urandom_range(0, 3));
        model_build();
        drive_op(1'b0, 1'b1, 0, 0);
        checks++;
        if (obs_done_cyc() !== model_latency()) begin
            errors++;
            $display("FAIL hold_first done_cycle: got %0d want %0d", obs_done_cyc(), model_latency());
        end
        @(negedge clk);
        checks++;
        if (obs !== W_IDLE) begin
            errors++;
            $display("FAIL hold_gap: got %b want %b", obs, W_IDLE);
        end
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) pat[i] = 2'($urandom_range(0, 3));
        model_build();
        drive_op(1'b1, 1'b0, 0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL hold_second cyc%0d: got %b want %b", k + 1, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        for (int i = 0; i < N; i++) pat[i] = 2'b00;
        model_build();
        drive_op(1'b0, 1'b0, 0, 9);
        checks++;
        if (obs_q.size() !== 9 || obs_q[obs_q.size() - 1] !== W_SHIFT) begin
            errors++;
            $display("FAIL abort_point: samples=%0d last=%b want 9 and %b", obs_q.size(),
                     obs_q[obs_q.size() - 1], W_SHIFT);
        end
        checks++;
        if (abort_obs !== W_IDLE) begin
            errors++;
            $display("FAIL abort_async: got %b want %b", abort_obs, W_IDLE);
        end
        @(posedge clk); #1;
        start = 1'b0;
        rst_b = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== W_IDLE) begin
                errors++;
                $display("FAIL abort_quiet cyc%0d: got %b want %b", k, obs, W_IDLE);
            end
            @(posedge clk); #1;
        end
        model_build();
        drive_op(1'b0, 1'b0, 0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL after_abort cyc%0d: got %b want %b", k + 1, obs_q[k], exp_q[k]);
            end
        end
        checks++;
        if (obs_done_cyc() !== 20) begin
            errors++;
            $display("FAIL after_abort done_cycle: got %0d want 20", obs_done_cyc());
        end
    endtask

    initial begin
        rst_b = 1'b1;
        start = 1'b0;
        q0 = 1'b0;
        q_m1 = 1'b0;
        #2;
        test_reset();
        test_patterns();
        test_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
